rv_regbank_sequencer: RTL
=========================

// Module: rv_regbank_sequencer
// PURPOSE
//  Parametrised multi-cycle RISC-V control core: instruction-fetch FSM, register bank and execute/write-back sequencing.
//  Fetches words from instruction memory over a req/ack handshake and reads rs1/rs2 from the bank.
//  Hands the decoded instruction to an external execute unit over a valid/ready handshake, then writes its result back.
//  Halts on SYSTEM; sits between SOC memory and the ALU/branch unit.
// PARAMETERS
//  XLEN      32  register/data width
//  NREGS     32  implemented registers (32 = RV32I, 16 = RV32E); x0 always reads 0
//  ADDR_W    8   word-address width of PC / imem_addr
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  CLK           in   1       system clock
//  RESET         in   1       async reset, active-high
//  imem_req      out  1       instruction fetch request
//  imem_addr     out  ADDR_W  word address (= PC)
//  imem_ack      in   1       fetch data valid this cycle
//  imem_rdata    in   32      instruction word
//  instr         out  32      current instruction register
//  pc            out  ADDR_W  current PC
//  rs1_val       out  XLEN    registered rs1 operand
//  rs2_val       out  XLEN    registered rs2 operand
//  ex_valid      out  1       instr/operands valid for execute unit
//  ex_ready      in   1       execute unit done; result ports valid
//  ex_wb_en      in   1       write ex_wb_data to rd
//  ex_wb_data    in   XLEN    write-back value
//  ex_pc_load    in   1       take ex_pc_target instead of PC+1
//  ex_pc_target  in   ADDR_W  branch/jump target (word address)
//  resume        in   1       leave HALT
//  halted        out  1       FSM in HALT
//  state         out  3       FSM state code (LED/debug)
//  dbg_addr      in   5       debug read register index
//  dbg_data      out  XLEN    RF[dbg_addr], 1-cycle latency
// BEHAVIOUR
//  Reset (async): PC=RESET_PC, state=FETCH, instr=32'h0000_0033 (NOP), rs1_val=rs2_val=dbg_data=0, all RF=0,
//    imem_req=0, ex_valid=0, halted=0. Outstanding fetch abandoned; ack after reset is ignored unless in FETCH.
//  States: FETCH=0, REGS=1, EXEC=2, HALT=3 (others unused, decode to FETCH).
//  FETCH:
//    - imem_req=1, imem_addr=PC, held until imem_ack.
//    - On ack: instr<=imem_rdata, go REGS.
//    - Ack in the first req cycle is legal (min 1 cycle).
//  REGS:
//    - rs1_val<=RF[instr[19:15]], rs2_val<=RF[instr[24:20]].
//    - Index 0 or >=NREGS reads 0.
//    - Go EXEC next cycle.
//  EXEC:
//    - ex_valid=1 (decoded from state), held until ex_ready; ex_ready same cycle as entry is legal.
//    - On ex_valid&&ex_ready, opcode==7'b1110011 (SYSTEM): no write, PC unchanged, go HALT.
//    - Else: if ex_wb_en && rd!=0 && rd<NREGS, RF[instr[11:7]]<=ex_wb_data.
//    - PC<=ex_pc_load ? ex_pc_target : PC+1, go FETCH.
//  HALT:
//    - halted=1, no req.
//    - resume -> PC<=PC+1, go FETCH. resume outside HALT is ignored.
//  Arithmetic: PC wraps modulo 2^ADDR_W (max+1 -> 0). Writes to x0 or rd>=NREGS are dropped.
//  Write-back occurs in the handshake cycle; the next REGS read (>=2 cycles later) sees the new value.
//  dbg_data<=RF[dbg_addr] every cycle, including HALT (0 for idx 0 or >=NREGS).
//  imem_ack and ex_ready outside their state have no effect.
// TESTING
//  1. MEM: add x1,x0,x0; 4x addi x1,x1,1; ebreak, ALU model, ack=1 -> halted at PC=5, dbg x1=4, 4 cycles/instr.
//  2. imem_ack delayed 3 cycles -> imem_req high 4 cycles, addr stable, instr latched only on ack.
//  3. EXEC with ex_wb_en=1, rd=0, data=0xDEADBEEF -> dbg x0 reads 0; rd=5 -> x5=0xDEADBEEF.
//  4. NREGS=16, write rd=20 -> no change anywhere; read rs1=20 gives 0.
//  5. PC=255 (ADDR_W=8), no branch -> PC=0; ex_pc_load=1, target=0x10 -> next imem_addr=0x10.
//  6. RESET mid-EXEC and mid-FETCH -> outputs at reset values immediately; HALT+resume -> FETCH at PC+1.

Source files
------------

// File: rtl/rv_regbank_sequencer.sv
// Multi-cycle RISC-V control core: fetch FSM, register bank, and execute/write-back
// sequencing around an external execute unit.
module rv_regbank_sequencer #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_rdata_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [XLEN-1:0]   rs1_val_o,
  output logic [XLEN-1:0]   rs2_val_o,
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  input  logic              ex_wb_en_i,
  input  logic [XLEN-1:0]   ex_wb_data_i,
  input  logic              ex_pc_load_i,
  input  logic [ADDR_W-1:0] ex_pc_target_i,
  input  logic              resume_i,
  output logic              halted_o,
  output logic [2:0]        state_o,
  input  logic [4:0]        dbg_addr_i,
  output logic [XLEN-1:0]   dbg_data_o
);

  localparam int unsigned IDX_W     = $clog2(NREGS);
  localparam logic [31:0] NOP       = 32'h0000_0033;
  localparam logic [6:0]  OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_REGS  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_HALT  = 3'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic [XLEN-1:0]     rs1_q, rs1_d, rs2_q, rs2_d, dbg_q;
  logic                req_q, req_d, ex_valid_q, ex_valid_d, halted_q, halted_d;
  logic                wb_en_c;
  logic [4:0]          rd_c;
  logic [XLEN-1:0]     rf_q [NREGS];

  // x0 and indices beyond the implemented bank read as zero
  function automatic logic [XLEN-1:0] rf_read(input logic [XLEN-1:0] rf [NREGS],
                                              input logic [4:0] idx);
    if (idx == 5'd0 || 32'(idx) >= NREGS) return '0;
    return rf[idx[IDX_W-1:0]];
  endfunction

  assign rd_c = instr_q[11:7];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    wb_en_c  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (req_q && imem_ack_i) begin
          instr_d = imem_rdata_i;
          state_d = ST_REGS;
        end
      end
      ST_REGS: begin
        rs1_d   = rf_read(rf_q, instr_q[19:15]);
        rs2_d   = rf_read(rf_q, instr_q[24:20]);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (ex_valid_q && ex_ready_i) begin
          if (instr_q[6:0] == OP_SYSTEM) begin
            state_d = ST_HALT;
          end else begin
            wb_en_c = ex_wb_en_i && (rd_c != 5'd0) && (32'(rd_c) < NREGS);
            pc_d    = ex_pc_load_i ? ex_pc_target_i : pc_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        if (resume_i) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
    // request rises one cycle after entering FETCH and drops on the accepting edge
    req_d      = (state_q == ST_FETCH) && (state_d == ST_FETCH);
    ex_valid_d = (state_d == ST_EXEC);
    halted_d   = (state_d == ST_HALT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_FETCH;
      pc_q       <= ADDR_W'(RESET_PC);
      instr_q    <= NOP;
      rs1_q      <= '0;
      rs2_q      <= '0;
      dbg_q      <= '0;
      req_q      <= 1'b0;
      ex_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      dbg_q      <= rf_read(rf_q, dbg_addr_i);
      req_q      <= req_d;
      ex_valid_q <= ex_valid_d;
      halted_q   <= halted_d;
      if (wb_en_c) rf_q[rd_c[IDX_W-1:0]] <= ex_wb_data_i;
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign instr_o     = instr_q;
  assign rs1_val_o   = rs1_q;
  assign rs2_val_o   = rs2_q;
  assign ex_valid_o  = ex_valid_q;
  assign halted_o    = halted_q;
  assign state_o     = 3'(state_q);
  assign dbg_data_o  = dbg_q;

endmodule
